// File: rtl/game_pkg.sv
// Shared types and helpers for the Bulls-and-Cows game: state encoding,
// segment constants and the thermometer helper for the LED bars.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP_J1 = 3'd1,
    S_SETUP_J2 = 3'd2,
    S_GUESS_J1 = 3'd3,
    S_GUESS_J2 = 3'd4,
    S_WIN_J1   = 3'd5,
    S_WIN_J2   = 3'd6
  } game_state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Bit i is set iff i < min(p, l); callers keep the low l bits.
  function automatic logic [63:0] thermo(input logic [7:0] p, input int l);
    logic [63:0] bar;
    int lim;
    lim = (int'(p) < l) ? int'(p) : l;
    bar = '0;
    for (int i = 0; i < 64; i++) begin
      bar[i] = (i < lim);
    end
    return bar;
  endfunction

endpackage

// File: rtl/game_display_ctrl_seg7_encoder.sv
// Active-low gfedcba encoder for one digit; blank wins over dash, dash over value.
import game_pkg::*;

module seg7_encoder (
  input  logic       blank,
  input  logic       dash,
  input  logic [3:0] value,
  output logic [6:0] ddp
);

  always_comb begin
    ddp = SEG_BLANK[6:0];
    if (blank) begin
      ddp = SEG_BLANK[6:0];
    end else if (dash) begin
      ddp = SEG_DASH[6:0];
    end else begin
      case (value)
        4'd0:    ddp = 7'h40;
        4'd1:    ddp = 7'h79;
        4'd2:    ddp = 7'h24;
        4'd3:    ddp = 7'h30;
        4'd4:    ddp = 7'h19;
        4'd5:    ddp = 7'h12;
        4'd6:    ddp = 7'h02;
        4'd7:    ddp = 7'h78;
        4'd8:    ddp = 7'h00;
        4'd9:    ddp = 7'h10;
        default: ddp = SEG_BLANK[6:0];
      endcase
    end
  end

endmodule

// File: rtl/game_display_ctrl.sv
// Scoreboard driver: scans the 7-segment digits with a blanking cycle between
// slots and drives the two player LED bars, blinking the winner's bar.
import game_pkg::*;

module game_display_ctrl #(
  parameter int NUM_DIGITS      = 8,
  parameter int REFRESH_DIV     = 100000,
  parameter int LEDS_PER_PLAYER = 8,
  parameter int BLINK_DIV       = 25000000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [7:0]                   j1_points,
  input  logic [7:0]                   j2_points,
  input  logic [2:0]                   bull_count,
  input  logic [2:0]                   cow_count,
  input  logic [2:0]                   game_state,
  output logic [NUM_DIGITS-1:0]        an,
  output logic [7:0]                   ddp,
  output logic [2*LEDS_PER_PLAYER-1:0] led
);

  localparam int L     = LEDS_PER_PLAYER;
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] digit_idx;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_on;
  logic             tick;
  logic             in_win;
  game_state_t      st;

  logic [6:0] j1_sat, j2_sat;
  logic [3:0] j1_tens, j1_units, j2_tens, j2_units;
  logic       dig_blank, dig_dash, dp_n;
  logic [3:0] dig_val;
  logic [6:0] seg;
  logic [63:0] thermo1, thermo2;
  logic [L-1:0] bar1, bar2;
  logic         unused_thermo;

  // The reserved code 7 behaves like idle.
  always_comb begin
    st = S_IDLE;
    if (game_state != 3'd7) st = game_state_t'(game_state);
  end

  assign tick   = (div_cnt == DIV_W'(REFRESH_DIV - 1));
  assign in_win = (st == S_WIN_J1) || (st == S_WIN_J2);

  assign j1_sat   = (j1_points > 8'd99) ? 7'd99 : j1_points[6:0];
  assign j2_sat   = (j2_points > 8'd99) ? 7'd99 : j2_points[6:0];
  assign j1_tens  = 4'(j1_sat / 7'd10);
  assign j1_units = 4'(j1_sat % 7'd10);
  assign j2_tens  = 4'(j2_sat / 7'd10);
  assign j2_units = 4'(j2_sat % 7'd10);

  assign thermo1       = thermo(j1_points, L);
  assign thermo2       = thermo(j2_points, L);
  assign bar1          = thermo1[L-1:0];
  assign bar2          = thermo2[L-1:0];
  assign unused_thermo = ^{thermo1[63:L], thermo2[63:L]};

  // Digit content selection; tens digits of zero are suppressed.
  always_comb begin
    dig_blank = 1'b0;
    dig_dash  = 1'b0;
    dig_val   = 4'd0;
    if (st == S_IDLE) begin
      if (int'(digit_idx) < 6) dig_dash = 1'b1;
      else                     dig_blank = 1'b1;
    end else begin
      case (int'(digit_idx))
        0: dig_val = {1'b0, cow_count};
        1: dig_val = {1'b0, bull_count};
        2: dig_val = j2_units;
        3: begin
          dig_val   = j2_tens;
          dig_blank = (j2_tens == 4'd0);
        end
        4: dig_val = j1_units;
        5: begin
          dig_val   = j1_tens;
          dig_blank = (j1_tens == 4'd0);
        end
        default: dig_blank = 1'b1;
      endcase
    end
  end

  assign dp_n = !(((st == S_GUESS_J1) || (st == S_GUESS_J2)) && (int'(digit_idx) == 1));

  seg7_encoder u_seg (
    .blank (dig_blank),
    .dash  (dig_dash),
    .value (dig_val),
    .ddp   (seg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
      end
    end
  end

  // Blink phase restarts lit every time a win state is entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (in_win) begin
      if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end else begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end
  end

  // Slot boundaries get one fully dark cycle to avoid ghosting on the next digit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an  <= '1;
      ddp <= SEG_BLANK;
      led <= '0;
    end else begin
      if (tick) begin
        an  <= '1;
        ddp <= SEG_BLANK;
      end else begin
        an  <= ~(NUM_DIGITS'(1) << digit_idx);
        ddp <= {dp_n, seg};
      end
      led[L-1:0]   <= (st == S_WIN_J1) ? {L{blink_on}} : bar1;
      led[2*L-1:L] <= (st == S_WIN_J2) ? {L{blink_on}} : bar2;
    end
  end

endmodule

// File: tb/tb_game_display_ctrl.sv
// Scoreboard bench for game_display_ctrl: a spec-level model pushes expected
// outputs per driven cycle, a negedge checker pops and compares them.
module tb_game_display_ctrl;

  localparam int ND = 8;
  localparam int RD = 4;
  localparam int L  = 8;
  localparam int BD = 8;

  logic          clock, reset;
  logic [7:0]    j1_points, j2_points;
  logic [2:0]    bull_count, cow_count, game_state;
  logic [ND-1:0] an;
  logic [7:0]    ddp;
  logic [2*L-1:0] led;

  typedef struct {
    logic [7:0]  an;
    logic [7:0]  ddp;
    logic [15:0] led;
  } exp_t;

  exp_t expQ[$];
  exp_t popE;
  int   nCompares = 0;
  int   nMiscompares = 0;

  int         mDiv, mIdx, mBlinkCnt;
  logic       mBlinkOn;
  logic [7:0] lastExpAn;

  logic [7:0] digitSeen [ND];
  int         seqQ[$];
  logic       seqEn;
  int         lastIdx;
  int         seenIdx;

  game_display_ctrl #(
    .NUM_DIGITS      (ND),
    .REFRESH_DIV     (RD),
    .LEDS_PER_PLAYER (L),
    .BLINK_DIV       (BD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .j1_points  (j1_points),
    .j2_points  (j2_points),
    .bull_count (bull_count),
    .cow_count  (cow_count),
    .game_state (game_state),
    .an         (an),
    .ddp        (ddp),
    .led        (led)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompares++;
    if (observed !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] segOf(input int v);
    case (v)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] expDdp(input int st, input int idx, input int p1, input int p2,
                                        input int b, input int c);
    int s1, s2;
    logic [7:0] v;
    if (st == 0 || st == 7) return (idx < 6) ? 8'hBF : 8'hFF;
    s1 = (p1 > 99) ? 99 : p1;
    s2 = (p2 > 99) ? 99 : p2;
    case (idx)
      0: v = segOf(c);
      1: v = segOf(b);
      2: v = segOf(s2 % 10);
      3: v = (s2 / 10 == 0) ? 8'hFF : segOf(s2 / 10);
      4: v = segOf(s1 % 10);
      5: v = (s1 / 10 == 0) ? 8'hFF : segOf(s1 / 10);
      default: v = 8'hFF;
    endcase
    if (idx == 1 && (st == 3 || st == 4)) v[7] = 1'b0;
    return v;
  endfunction

  function automatic logic [7:0] barOf(input int p);
    logic [7:0] b;
    for (int i = 0; i < L; i++) b[i] = (p > i);
    return b;
  endfunction

  task automatic resetModel();
    mDiv = 0;
    mIdx = 0;
    mBlinkCnt = 0;
    mBlinkOn = 1'b1;
  endtask

  // Drive one cycle of inputs, queue what the next edge must produce, then step.
  task automatic applyStimulus(input int st, input int p1, input int p2, input int b, input int c);
    exp_t e;
    logic tk;
    game_state = 3'(st);
    j1_points  = 8'(p1);
    j2_points  = 8'(p2);
    bull_count = 3'(b);
    cow_count  = 3'(c);
    tk = (mDiv == RD - 1);
    e.an  = tk ? 8'hFF : ~(8'h01 << mIdx);
    e.ddp = tk ? 8'hFF : expDdp(st, mIdx, p1, p2, b, c);
    e.led[7:0]  = (st == 5) ? (mBlinkOn ? 8'hFF : 8'h00) : barOf(p1);
    e.led[15:8] = (st == 6) ? (mBlinkOn ? 8'hFF : 8'h00) : barOf(p2);
    expQ.push_back(e);
    lastExpAn = e.an;
    if (tk) begin
      mDiv = 0;
      mIdx = (mIdx == ND - 1) ? 0 : mIdx + 1;
    end else begin
      mDiv++;
    end
    if (st == 5 || st == 6) begin
      if (mBlinkCnt == BD - 1) begin
        mBlinkCnt = 0;
        mBlinkOn = ~mBlinkOn;
      end else begin
        mBlinkCnt++;
      end
    end else begin
      mBlinkCnt = 0;
      mBlinkOn = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("an_onehot0", 32'($onehot0(~an)), 32'd1);
      assert ($onehot0(~an)) else $error("[TB] an multi-hot: %h", an);
      if (expQ.size() > 0) begin
        popE = expQ.pop_front();
        checkOutput("an", 32'(an), 32'(popE.an));
        checkOutput("ddp", 32'(ddp), 32'(popE.ddp));
        checkOutput("led", 32'(led), 32'(popE.led));
      end
      if (an != 8'hFF) begin
        seenIdx = -1;
        for (int i = 0; i < ND; i++) if (!an[i]) seenIdx = i;
        if (seenIdx >= 0) begin
          digitSeen[seenIdx] = ddp;
          if (seqEn && seenIdx != lastIdx) seqQ.push_back(seenIdx);
          lastIdx = seenIdx;
        end
      end
    end
  end

  task automatic clearSeen();
    for (int i = 0; i < ND; i++) digitSeen[i] = 8'h00;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : main
    logic [7:0] frameTab [ND];
    logic [7:0] ledTab [4];
    int         j1Tab [4];

    reset = 1'b1;
    game_state = 3'd0;
    j1_points = 8'd0;
    j2_points = 8'd0;
    bull_count = 3'd0;
    cow_count = 3'd0;
    seqEn = 1'b0;
    lastIdx = -1;
    lastExpAn = 8'hFF;
    resetModel();
    clearSeen();
    #12;
    reset = 1'b0;

    // Scan into digit 3, then reset in the middle of its slot.
    for (int k = 0; k < 40; k++) begin
      applyStimulus(3, 57, 3, 2, 1);
      if (lastExpAn == 8'hF7) break;
    end
    checkOutput("pre_reset_an", 32'(an), 32'hF7);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("reset_an", 32'(an), 32'hFF);
    checkOutput("reset_ddp", 32'(ddp), 32'hFF);
    checkOutput("reset_led", 32'(led), 32'h0);
    expQ.delete();
    resetModel();
    @(posedge clock);
    #1;
    checkOutput("reset_hold_an", 32'(an), 32'hFF);
    @(negedge clock);
    #2;
    reset = 1'b0;
    lastIdx = -1;
    seqEn = 1'b1;
    clearSeen();

    // Two full frames of a guess display.
    for (int k = 0; k < 2 * ND * RD; k++) applyStimulus(3, 57, 3, 2, 1);
    seqEn = 1'b0;
    frameTab = '{8'hF9, 8'h24, 8'hB0, 8'hFF, 8'hF8, 8'h92, 8'hFF, 8'hFF};
    for (int i = 0; i < ND; i++)
      checkOutput($sformatf("guess_digit%0d", i), 32'(digitSeen[i]), 32'(frameTab[i]));
    checkOutput("seq_len", 32'(seqQ.size() >= 9), 32'd1);
    if (seqQ.size() >= 9) begin
      for (int i = 0; i < 9; i++) checkOutput($sformatf("seq%0d", i), 32'(seqQ[i]), 32'(i % ND));
    end

    // LED bar thermometer and score saturation.
    j1Tab  = '{0, 3, 8, 200};
    ledTab = '{8'h00, 8'h07, 8'hFF, 8'hFF};
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) applyStimulus(4, j1Tab[k], 255, 0, 0);
      checkOutput($sformatf("led_j1_%0d", j1Tab[k]), 32'(led[7:0]), 32'(ledTab[k]));
      checkOutput($sformatf("led_j2_255_%0d", k), 32'(led[15:8]), 32'hFF);
    end
    clearSeen();
    for (int k = 0; k < ND * RD + 4; k++) applyStimulus(4, 150, 255, 4, 0);
    checkOutput("sat_j1_tens", 32'(digitSeen[5]), 32'h90);
    checkOutput("sat_j1_units", 32'(digitSeen[4]), 32'h90);

    // Idle and the reserved code both show dashes.
    for (int s = 0; s < 2; s++) begin
      clearSeen();
      for (int k = 0; k < ND * RD + 4; k++) applyStimulus((s == 0) ? 0 : 7, 42, 17, 3, 2);
      for (int i = 0; i < ND; i++)
        checkOutput($sformatf("idle%0d_digit%0d", s, i), 32'(digitSeen[i]), (i < 6) ? 32'hBF : 32'hFF);
    end

    // Winner bar blinks with an 8-cycle half period starting lit.
    for (int k = 0; k < 4 * BD; k++) begin
      applyStimulus(6, 4, 2, 0, 0);
      checkOutput($sformatf("blink%0d", k), 32'(led[15:8]), ((k / BD) % 2 == 0) ? 32'hFF : 32'h00);
      checkOutput($sformatf("loser%0d", k), 32'(led[7:0]), 32'h0F);
    end
    applyStimulus(3, 4, 2, 0, 0);
    checkOutput("after_win_j2_bar", 32'(led[15:8]), 32'h03);

    @(negedge clock);
    #1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nCompares, nMiscompares);
    $finish;
  end

endmodule
